serial_frame_rx: RTL

Serial frame receiver that consumes the one-bit-per-clock stream produced by the upstream D flip-flop stage (its `q` drives `d` here). It detects a start bit, shifts in `DATA_W` data bits LSB-first, checks an even-parity bit and a stop bit, and presents the assembled word on a valid/ready output port. Error and overrun status travel with each word.

---
 rtl/serial_frame_pkg.sv | 16 +
 rtl/frame_shift_reg.sv | 43 ++++
 rtl/serial_frame_rx.sv | 133 +++++++++++++
 3 files changed

// File: rtl/serial_frame_pkg.sv
// Shared state encoding and line-level constants for the serial frame receiver.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    RESYNC
  } state_e;

  localparam logic START_LVL = 1'b1;
  localparam logic STOP_LVL  = 1'b0;
  localparam logic IDLE_LVL  = 1'b0;

endpackage

// File: rtl/frame_shift_reg.sv
// LSB-first serial-to-parallel shift register with a running XOR of every bit shifted in.
module frame_shift_reg #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              shift_i,
  input  logic              bit_i,
  output logic [DATA_W-1:0] data_o,
  output logic              parity_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              par_q, par_d;

  // New bits enter at the MSB so the first bit lands in bit 0 after DATA_W shifts.
  always_comb begin
    data_d = data_q;
    par_d  = par_q;
    if (clr_i) begin
      data_d = '0;
      par_d  = 1'b0;
    end else if (shift_i) begin
      data_d = {bit_i, data_q[DATA_W-1:1]};
      par_d  = par_q ^ bit_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      par_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      par_q  <= par_d;
    end
  end

  assign data_o   = data_q;
  assign parity_o = par_q;

endmodule

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start/data/even-parity/stop framing, valid/ready output with
// per-word error flags and a sticky overrun indicator.
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              d,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              perr_pend_q, perr_pend_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  logic              sr_clr, sr_shift;
  logic [DATA_W-1:0] sr_data;
  logic              sr_parity;

  frame_shift_reg #(
    .DATA_W (DATA_W)
  ) u_shift (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (sr_clr),
    .shift_i  (sr_shift),
    .bit_i    (d),
    .data_o   (sr_data),
    .parity_o (sr_parity)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    perr_pend_d = perr_pend_q;
    sr_clr      = 1'b0;
    sr_shift    = 1'b0;
    data_d      = data_q;
    valid_d     = valid_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    ovr_d       = ovr_q;

    if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (d == START_LVL) begin
          state_d = DATA;
          cnt_d   = '0;
          sr_clr  = 1'b1;
        end
      end
      DATA: begin
        sr_shift = 1'b1;
        if (cnt_q == CntLast) begin
          state_d = PARITY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        perr_pend_d = d ^ sr_parity;
        state_d     = STOP;
      end
      STOP: begin
        // Output is free if empty or being drained on this same edge.
        if (!valid_q || data_ready) begin
          data_d  = sr_data;
          perr_d  = perr_pend_q;
          ferr_d  = (d != STOP_LVL);
          valid_d = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
        state_d = (d == STOP_LVL) ? IDLE : RESYNC;
      end
      RESYNC: begin
        if (d == IDLE_LVL) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      perr_pend_q <= 1'b0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      perr_pend_q <= perr_pend_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      ovr_q       <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign data_valid = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule
